// File: rtl/stage_4_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_4_mem                                                  |
// | Description : Pipeline MEM stage: load data extraction, final result and   |
// |               forwarding bus, with SRAM read data retained across stalls.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stage_4_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_3,
  output logic        allow_4,
  input  logic [73:0] stage_3_to_4,
  input  logic [31:0] data_sram_rdata,
  output logic        valid_4,
  input  logic        allow_5,
  output logic [69:0] stage_4_to_5,
  output logic        mem_fwd_we,
  output logic [4:0]  mem_fwd_dest,
  output logic [31:0] mem_fwd_data
);

  localparam logic c_ready_go = 1'b1;

  logic        r_valid;
  logic [73:0] r_bus;
  logic [31:0] r_rdata_buf;
  logic        r_rdata_held;
  logic        r_first_cyc;

  logic [2:0]  w_mem_op;
  logic        w_res_from_mem;
  logic        w_rf_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [1:0]  w_off;
  logic [31:0] w_rdata_eff;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_enter;

  assign w_mem_op       = r_bus[73:71];
  assign w_res_from_mem = r_bus[70];
  assign w_rf_we        = r_bus[69];
  assign w_dest         = r_bus[68:64];
  assign w_alu_result   = r_bus[63:32];
  assign w_pc           = r_bus[31:0];
  assign w_off          = w_alu_result[1:0];

  assign allow_4 = !r_valid | (c_ready_go & allow_5);
  assign valid_4 = r_valid & c_ready_go;
  assign w_enter = valid_3 & allow_4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_bus        <= 74'b0;
      r_rdata_buf  <= 32'b0;
      r_rdata_held <= 1'b0;
      r_first_cyc  <= 1'b0;
    end else begin
      if (allow_4) begin
        r_valid <= valid_3;
      end
      if (w_enter) begin
        r_bus        <= stage_3_to_4;
        r_first_cyc  <= 1'b1;
        r_rdata_held <= 1'b0;
      end else begin
        r_first_cyc <= 1'b0;
        // SRAM data is only presented in the first cycle; keep it if WB stalls us
        if (r_valid & r_first_cyc & !allow_5) begin
          r_rdata_buf  <= data_sram_rdata;
          r_rdata_held <= 1'b1;
        end else if (r_valid & allow_5) begin
          r_rdata_held <= 1'b0;
        end
      end
    end
  end

  assign w_rdata_eff = r_rdata_held ? r_rdata_buf : data_sram_rdata;
  assign w_half      = w_off[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];

  always_comb begin
    w_byte = w_rdata_eff[7:0];
    case (w_off)
      2'd1:    w_byte = w_rdata_eff[15:8];
      2'd2:    w_byte = w_rdata_eff[23:16];
      2'd3:    w_byte = w_rdata_eff[31:24];
      default: w_byte = w_rdata_eff[7:0];
    endcase
  end

  always_comb begin
    w_load_data = w_rdata_eff;
    case (w_mem_op)
      3'b001:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b101:  w_load_data = {24'b0, w_byte};
      3'b010:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b110:  w_load_data = {16'b0, w_half};
      default: w_load_data = w_rdata_eff;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

  // rf_we leaves ungated; WB qualifies it with its own valid
  assign stage_4_to_5 = {w_rf_we, w_dest, w_final_result, w_pc};
  assign mem_fwd_we   = r_valid & w_rf_we;
  assign mem_fwd_dest = w_dest;
  assign mem_fwd_data = w_final_result;

endmodule
`default_nettype wire

// File: tb/tb_stage_4_mem.sv
`default_nettype none
// Testbench for stage_4_mem: directed stimulus, scoreboard of expected WB
// transfers and per-cycle probes of handshake/bus state.
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_3;
  logic        allow_4;
  logic [73:0] stage_3_to_4;
  logic [31:0] data_sram_rdata;
  logic        valid_4;
  logic        allow_5;
  logic [69:0] stage_4_to_5;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_dest;
  logic [31:0] mem_fwd_data;

  always #5 clk = ~clk;

  stage_4_mem dut (
    .clk             (clk),
    .reset           (reset),
    .valid_3         (valid_3),
    .allow_4         (allow_4),
    .stage_3_to_4    (stage_3_to_4),
    .data_sram_rdata (data_sram_rdata),
    .valid_4         (valid_4),
    .allow_5         (allow_5),
    .stage_4_to_5    (stage_4_to_5),
    .mem_fwd_we      (mem_fwd_we),
    .mem_fwd_dest    (mem_fwd_dest),
    .mem_fwd_data    (mem_fwd_data)
  );

  typedef struct {
    logic        is_end;
    logic        chk_bus;
    logic        v4;
    logic        a4;
    logic        fwe;
    logic [69:0] bus;
  } probe_t;

  logic [69:0] sb_q[$];
  probe_t      probe_q[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [73:0] mk(input logic [2:0] op, input logic rfm, input logic we,
                                     input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {op, rfm, we, dst, alu, pc};
  endfunction

  function automatic logic [69:0] ex(input logic we, input logic [4:0] dst,
                                     input logic [31:0] res, input logic [31:0] pc);
    return {we, dst, res, pc};
  endfunction

  // Monitor: probes of the current cycle first, then any transfer to WB.
  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      probe_t p;
      p = probe_q.pop_front();
      if (p.is_end) begin
        checks++;
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d transfers outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end else begin
        checks++;
        if (valid_4 !== p.v4 || allow_4 !== p.a4 || mem_fwd_we !== p.fwe) begin
          errors++;
          $display("FAIL handshake @%0t: v4/a4/fwe got %b%b%b required %b%b%b",
                   $time, valid_4, allow_4, mem_fwd_we, p.v4, p.a4, p.fwe);
        end
        if (p.chk_bus) begin
          checks++;
          if (stage_4_to_5 !== p.bus) begin
            errors++;
            $display("FAIL bus_probe @%0t: got %h required %h", $time, stage_4_to_5, p.bus);
          end
        end
      end
    end
    if (valid_4 === 1'b1 && allow_5 === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL xfer @%0t: unexpected transfer %h, required none", $time, stage_4_to_5);
      end else begin
        logic [69:0] e;
        e = sb_q.pop_front();
        if (stage_4_to_5 !== e || mem_fwd_data !== e[63:32] ||
            mem_fwd_dest !== e[68:64] || mem_fwd_we !== e[69]) begin
          errors++;
          $display("FAIL xfer @%0t: bus %h fwd %b/%h/%h, required bus %h",
                   $time, stage_4_to_5, mem_fwd_we, mem_fwd_dest, mem_fwd_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: summary not reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic v3, input logic [73:0] b, input logic [31:0] rd, input logic a5);
    valid_3         = v3;
    stage_3_to_4    = b;
    data_sram_rdata = rd;
    allow_5         = a5;
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic v4, input logic a4, input logic fwe,
                       input logic chk, input logic [69:0] bus);
    probe_t p;
    p.is_end = 1'b0; p.chk_bus = chk; p.v4 = v4; p.a4 = a4; p.fwe = fwe; p.bus = bus;
    probe_q.push_back(p);
  endtask

  logic [2:0]  ld_op  [10] = '{3'b001, 3'b101, 3'b001, 3'b010, 3'b110,
                               3'b000, 3'b011, 3'b110, 3'b101, 3'b010};
  logic [1:0]  ld_off [10] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
  logic [31:0] ld_exp [10] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF,
                               32'h00007F01, 32'h80FF7F01, 32'h80FF7F01, 32'h000080FF,
                               32'h0000007F, 32'h00007F01};

  initial begin
    logic [73:0] a2, l1, l3, l4, l5, l6;
    probe_t pe;
    reset = 1'b1; valid_3 = 1'b0; stage_3_to_4 = '0; data_sram_rdata = '0; allow_5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    probe(1'b0, 1'b1, 1'b0, 1'b1, 70'b0);
    cyc(1'b0, '0, 32'h0, 1'b1);

    // ALU op
    sb_q.push_back(ex(1'b1, 5'd5, 32'h12345678, 32'h1c000004));
    cyc(1'b1, mk(3'b000, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000004), 32'h0, 1'b1);
    probe(1'b1, 1'b1, 1'b1, 1'b1, ex(1'b1, 5'd5, 32'h12345678, 32'h1c000004));

    // Back-to-back loads over a constant read word
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(ex(1'b1, 5'(i + 1), ld_exp[i], 32'h1c001000 + 32'(4 * i)));
      cyc(1'b1, mk(ld_op[i], 1'b1, 1'b1, 5'(i + 1), 32'h00001000 + 32'(ld_off[i]),
                   32'h1c001000 + 32'(4 * i)), 32'h80FF7F01, 1'b1);
    end
    cyc(1'b0, '0, 32'h80FF7F01, 1'b1);
    probe(1'b0, 1'b1, 1'b0, 1'b0, 70'b0);
    cyc(1'b0, '0, 32'h0, 1'b1);

    // Stalled load: read data must survive while EX offers another op
    l1 = mk(3'b000, 1'b1, 1'b1, 5'd7, 32'h00000100, 32'h1c000100);
    a2 = mk(3'b000, 1'b0, 1'b1, 5'd9, 32'h55AA55AA, 32'h1c000200);
    sb_q.push_back(ex(1'b1, 5'd7, 32'hDEADBEEF, 32'h1c000100));
    cyc(1'b1, l1, 32'h0, 1'b0);
    probe(1'b1, 1'b0, 1'b1, 1'b1, ex(1'b1, 5'd7, 32'hDEADBEEF, 32'h1c000100));
    cyc(1'b1, a2, 32'hDEADBEEF, 1'b0);
    probe(1'b1, 1'b0, 1'b1, 1'b1, ex(1'b1, 5'd7, 32'hDEADBEEF, 32'h1c000100));
    cyc(1'b1, a2, 32'h0, 1'b0);
    probe(1'b1, 1'b0, 1'b1, 1'b1, ex(1'b1, 5'd7, 32'hDEADBEEF, 32'h1c000100));
    cyc(1'b1, a2, 32'h0, 1'b0);
    sb_q.push_back(ex(1'b1, 5'd9, 32'h55AA55AA, 32'h1c000200));
    cyc(1'b1, a2, 32'h0, 1'b1);

    // Held data must clear when a new load enters on the same edge the old one leaves
    l3 = mk(3'b001, 1'b1, 1'b1, 5'd10, 32'h00000200, 32'h1c000300);
    l4 = mk(3'b000, 1'b1, 1'b1, 5'd11, 32'h00000204, 32'h1c000304);
    sb_q.push_back(ex(1'b1, 5'd10, 32'h00000044, 32'h1c000300));
    cyc(1'b1, l3, 32'h0, 1'b1);
    probe(1'b1, 1'b0, 1'b1, 1'b0, 70'b0);
    cyc(1'b1, l4, 32'h11223344, 1'b0);
    sb_q.push_back(ex(1'b1, 5'd11, 32'hCAFEF00D, 32'h1c000304));
    cyc(1'b1, l4, 32'h0, 1'b1);
    cyc(1'b0, '0, 32'hCAFEF00D, 1'b1);

    // Reset during a stalled load discards it and its retained data
    l5 = mk(3'b000, 1'b1, 1'b1, 5'd12, 32'h00000300, 32'h1c000400);
    l6 = mk(3'b000, 1'b1, 1'b1, 5'd13, 32'h00000400, 32'h1c000500);
    cyc(1'b1, l5, 32'h0, 1'b0);
    probe(1'b1, 1'b0, 1'b1, 1'b0, 70'b0);
    cyc(1'b0, '0, 32'hAAAA5555, 1'b0);
    reset = 1'b1;
    cyc(1'b0, '0, 32'h0, 1'b0);
    reset = 1'b0;
    probe(1'b0, 1'b1, 1'b0, 1'b1, 70'b0);
    sb_q.push_back(ex(1'b1, 5'd13, 32'h0BADF00D, 32'h1c000500));
    cyc(1'b1, l6, 32'h0, 1'b1);
    cyc(1'b0, '0, 32'h0BADF00D, 1'b1);

    repeat (2) cyc(1'b0, '0, 32'h0, 1'b1);
    pe.is_end = 1'b1; pe.chk_bus = 1'b0; pe.v4 = 1'b0; pe.a4 = 1'b0; pe.fwe = 1'b0; pe.bus = '0;
    probe_q.push_back(pe);
    repeat (2) cyc(1'b0, '0, 32'h0, 1'b1);
  end

endmodule
`default_nettype wire
